// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared defaults and receiver state encoding for the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE  = ST_IDLE,
        RX_START = ST_START,
        RX_DATA  = ST_DATA,
        RX_STOP  = ST_STOP
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop single-bit synchronizer with a parameterised reset value.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver with a valid/ready output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxclk_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [SW-1:0] SAMPLE_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMPLE_END = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

    rx_state_e            state;
    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;
    logic                 stop_hit;
    logic                 frame_done;

    // Idle-high line: synchronizer resets to 1 so reset never looks like a start bit
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign stop_hit   = rxclk_en && (state == RX_STOP) && (sample_cnt == SAMPLE_END);
    assign frame_done = stop_hit && rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
        end else if (rxclk_en) begin
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state      <= RX_START;
                        sample_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (sample_cnt == SAMPLE_MID) begin
                        sample_cnt <= '0;
                        bit_cnt    <= '0;
                        state      <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (sample_cnt == SAMPLE_END) begin
                        shift      <= {rx_s, shift[DATA_BITS-1:1]};
                        sample_cnt <= '0;
                        bit_cnt    <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed
                    if (sample_cnt == SAMPLE_END) begin
                        state      <= RX_IDLE;
                        sample_cnt <= '0;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_hit && !rx_s;
            overrun   <= frame_done && valid && !ready;
            // A byte consumed this cycle frees the holding register for the new one
            if (frame_done && (!valid || ready)) begin
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (8N1, 16x oversampling).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int EN_DIV   = 27;
    localparam int BIT_CLKS = 16 * EN_DIV;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rxclk_en = 1'b0;
    logic       rx       = 1'b1;
    logic       ready    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int en_div   = 0;
    int val_cyc  = 0;
    int fe_cyc   = 0;
    int ov_cyc   = 0;
    int base_v, base_f, base_o;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxclk_en  (rxclk_en),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #10 clk = ~clk;

    // Strobe changes on the falling edge so it is stable at every rising edge
    always @(negedge clk) begin
        if (en_div == EN_DIV - 1) begin
            en_div   <= 0;
            rxclk_en <= 1'b1;
        end else begin
            en_div   <= en_div + 1;
            rxclk_en <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (valid)     val_cyc <= val_cyc + 1;
        if (frame_err) fe_cyc  <= fe_cyc + 1;
        if (overrun)   ov_cyc  <= ov_cyc + 1;
    end

    initial begin
        #(90000 * 20);
        $display("FAIL timeout: observed no end of test, expected finish before 90000 cycles");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic snap();
        base_v = val_cyc;
        base_f = fe_cyc;
        base_o = ov_cyc;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * BIT_CLKS) @(negedge clk);
    endtask

    task automatic wait_en();
        do @(posedge clk); while (!rxclk_en);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data", 32'(data), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);

        // Good frame 0xA5 with ready held high
        snap();
        send_frame(8'hA5, 1'b1);
        idle(2);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_valid_cycles", 32'(val_cyc - base_v), 32'd1);
        check("a5_frame_err", 32'(fe_cyc - base_f), 32'd0);
        check("a5_overrun", 32'(ov_cyc - base_o), 32'd0);

        // Start-bit glitch shorter than half a bit
        snap();
        rx = 1'b0;
        repeat (4) wait_en();
        @(negedge clk);
        idle(2);
        check("glitch_valid", 32'(val_cyc - base_v), 32'd0);
        check("glitch_frame_err", 32'(fe_cyc - base_f), 32'd0);
        check("glitch_overrun", 32'(ov_cyc - base_o), 32'd0);

        // Bad stop bit, then recovery
        snap();
        send_frame(8'h3C, 1'b0);
        idle(2);
        check("badstop_frame_err_cycles", 32'(fe_cyc - base_f), 32'd1);
        check("badstop_valid", 32'(val_cyc - base_v), 32'd0);
        check("badstop_overrun", 32'(ov_cyc - base_o), 32'd0);
        snap();
        send_frame(8'h11, 1'b1);
        idle(2);
        check("recover_data", 32'(data), 32'h11);
        check("recover_valid_cycles", 32'(val_cyc - base_v), 32'd1);

        // Overrun: consumer stalled across two back-to-back frames
        ready = 1'b0;
        snap();
        send_frame(8'h55, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(2);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_data_held", 32'(data), 32'h55);
        check("ovr_overrun_cycles", 32'(ov_cyc - base_o), 32'd1);
        check("ovr_frame_err", 32'(fe_cyc - base_f), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_drop", 32'(valid), 32'h0);

        // Reset pulse a quarter of the way into data bit 4
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b0;
        repeat (BIT_CLKS / 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        check("midrst_data", 32'(data), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        idle(2);
        check("midrst_no_valid", 32'(val_cyc - base_v), 32'd0);
        check("midrst_no_frame_err", 32'(fe_cyc - base_f), 32'd0);
        check("midrst_no_overrun", 32'(ov_cyc - base_o), 32'd0);
        snap();
        send_frame(8'h81, 1'b1);
        idle(2);
        check("after_rst_data", 32'(data), 32'h81);
        check("after_rst_valid_cycles", 32'(val_cyc - base_v), 32'd1);

        // Consume the held byte in exactly the cycle the next byte completes
        ready = 1'b0;
        send_frame(8'h42, 1'b1);
        idle(2);
        check("hold_valid", 32'(valid), 32'h1);
        check("hold_data", 32'(data), 32'h42);
        snap();
        fork
            send_frame(8'h7E, 1'b1);
            begin
                // rx_s goes low two edges after rx; start is taken on the next strobe,
                // and the stop bit is judged 8 + 8*16 + 16 strobes later
                @(posedge clk);
                @(posedge clk);
                wait_en();
                repeat (151) wait_en();
                @(negedge clk);
                repeat (EN_DIV - 1) @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        idle(2);
        check("coincide_data", 32'(data), 32'h7E);
        check("coincide_valid", 32'(valid), 32'h1);
        check("coincide_overrun", 32'(ov_cyc - base_o), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        check("coincide_valid_drop", 32'(valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving rxclk_en pulses per bit period (even, >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame (5..9).
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rxclk_en, input, 1 bit: single-cycle oversample strobe from the baud generator.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port data, output, DATA_BITS: last received byte.
REQ-008 SHALL have port valid, output, 1 bit: data holds an unconsumed byte.
REQ-009 SHALL have port ready, input, 1 bit: consumer accepts data when valid && ready.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer (rx_s) reset to 1 before any use.
REQ-013 SHALL advance the state machine and the sample/bit counters only on cycles with rxclk_en=1.
REQ-014 SHALL use states IDLE, START, DATA, STOP; sample_cnt width $clog2(OVERSAMPLE); bit_cnt width $clog2(DATA_BITS+1).
REQ-015 IDLE: on rxclk_en with rx_s=0 SHALL enter START with sample_cnt=0.
REQ-016 START: SHALL increment sample_cnt until it equals OVERSAMPLE/2-1, then enter DATA (sample_cnt=0, bit_cnt=0) if rx_s=0, else return to IDLE (glitch rejection, no output effect).
REQ-017 DATA: when sample_cnt=OVERSAMPLE-1 SHALL shift rx_s in LSB-first, zero sample_cnt, increment bit_cnt; after bit DATA_BITS-1, enter STOP.
REQ-018 STOP: when sample_cnt=OVERSAMPLE-1 SHALL return to IDLE (mid-stop bit, allowing back-to-back frames); if rx_s=1 the frame completes, else frame_err pulses next cycle and the byte is discarded.
REQ-019 On frame completion with valid=0, data SHALL load and valid SHALL assert on the next clk edge.
REQ-020 valid and data SHALL hold stable until a cycle with valid && ready; valid then deasserts next edge.
REQ-021 On completion with valid=1 and ready=0, overrun SHALL pulse one cycle; held data SHALL be unchanged; new byte dropped.
REQ-022 On completion coincident with valid && ready, new data SHALL load, valid SHALL stay 1, overrun SHALL NOT pulse.
REQ-023 rxclk_en held low SHALL freeze the FSM; ready/valid handshake SHALL still operate every cycle.

Reset
REQ-024 rst SHALL force state=IDLE, counters=0, shift register=0, data=0, valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-025 rst asserted mid-frame SHALL discard the partial byte with no valid, frame_err or overrun pulse.

Structure
REQ-026 Package uart_pkg SHALL hold the rx state enum typedef and default OVERSAMPLE/DATA_BITS constants.
REQ-027 Synchronizer SHALL be sub-module sync_2ff (1-bit, reset value parameter); all else inline.

Verification
REQ-028 clk 50 MHz, rxclk_en every 27 cycles, ready=1; send 0xA5 8N1 -> one valid cycle, data=0xA5, no errors.
REQ-029 rx low for 4 rxclk_en then high -> FSM back to IDLE, no valid/frame_err/overrun.
REQ-030 Send 0x3C with stop bit 0 -> frame_err one-cycle pulse, valid stays 0; next good frame 0x11 received.
REQ-031 ready=0; send 0x55 then 0x3C back-to-back -> valid=1, data=0x55, overrun one pulse; raise ready -> valid drops next cycle.
REQ-032 Assert rst for one cycle during DATA bit 4 of a frame -> all outputs 0; following frame 0x81 received correctly.
REQ-033 ready pulsed in the same cycle a second byte 0x7E completes -> data=0x7E, valid stays 1, no overrun.
